// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: Moore datapath controls per state, memory req/ack handshake,
// board load-PC override, and retired-instruction / illegal-opcode status for the display path.
module mips_mc_controller #(
  parameter int CNT_W = 16
) (
  input  logic             SYS_clk,
  input  logic             SYS_rst,
  input  logic             CTL_load,
  input  logic [5:0]       CTL_opcode,
  input  logic [5:0]       CTL_funct,
  input  logic             CTL_zero,
  input  logic             CTL_mem_ack,
  output logic             CTL_mem_req,
  output logic             CTL_mem_we,
  output logic             CTL_iord,
  output logic             CTL_ir_write,
  output logic             CTL_pc_en,
  output logic [1:0]       CTL_pc_src,
  output logic             CTL_alu_src_a,
  output logic [1:0]       CTL_alu_src_b,
  output logic [1:0]       CTL_alu_op,
  output logic             CTL_reg_dst,
  output logic             CTL_mem_to_reg,
  output logic             CTL_reg_write,
  output logic [3:0]       CTL_state,
  output logic [CNT_W-1:0] CTL_instr_cnt,
  output logic             CTL_illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_LOAD_PC  = 4'd12,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state;
  state_t           state_nxt;
  logic             load_q;
  logic             load_edge;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;
  logic             illegal;
  logic             funct_unused;

  // funct only matters to the ALU control decoder downstream
  assign funct_unused = ^CTL_funct;

  assign load_edge = CTL_load & ~load_q;

  always_comb begin
    state_nxt      = state;
    CTL_mem_req    = 1'b0;
    CTL_mem_we     = 1'b0;
    CTL_iord       = 1'b0;
    CTL_ir_write   = 1'b0;
    CTL_pc_en      = 1'b0;
    CTL_pc_src     = 2'd0;
    CTL_alu_src_a  = 1'b0;
    CTL_alu_src_b  = 2'd0;
    CTL_alu_op     = 2'd0;
    CTL_reg_dst    = 1'b0;
    CTL_mem_to_reg = 1'b0;
    CTL_reg_write  = 1'b0;
    case (state)
      S_FETCH: begin
        CTL_mem_req   = 1'b1;
        CTL_alu_src_b = 2'd1;
        // an ack coinciding with a load edge is dropped so IR/PC stay untouched
        CTL_ir_write  = CTL_mem_ack & ~load_edge;
        CTL_pc_en     = CTL_mem_ack & ~load_edge;
        if (CTL_mem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        CTL_alu_src_b = 2'd3;
        case (CTL_opcode)
          OP_RTYPE:     state_nxt = S_RTYPE_EX;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_ADDI:      state_nxt = S_ADDI_EX;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        CTL_alu_src_a = 1'b1;
        CTL_alu_src_b = 2'd2;
        state_nxt     = (CTL_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        CTL_mem_req = 1'b1;
        CTL_iord    = 1'b1;
        if (CTL_mem_ack) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        CTL_reg_write  = 1'b1;
        CTL_mem_to_reg = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_MEMWR: begin
        CTL_mem_req = 1'b1;
        CTL_iord    = 1'b1;
        CTL_mem_we  = 1'b1;
        if (CTL_mem_ack) state_nxt = S_FETCH;
      end
      S_RTYPE_EX: begin
        CTL_alu_src_a = 1'b1;
        CTL_alu_op    = 2'd2;
        state_nxt     = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        CTL_reg_write = 1'b1;
        CTL_reg_dst   = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_BEQ: begin
        CTL_alu_src_a = 1'b1;
        CTL_alu_op    = 2'd1;
        CTL_pc_src    = 2'd1;
        CTL_pc_en     = CTL_zero;
        state_nxt     = S_FETCH;
      end
      S_ADDI_EX: begin
        CTL_alu_src_a = 1'b1;
        CTL_alu_src_b = 2'd2;
        state_nxt     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        CTL_reg_write = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_JUMP: begin
        CTL_pc_src = 2'd2;
        CTL_pc_en  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_LOAD_PC: begin
        CTL_pc_src = 2'd3;
        CTL_pc_en  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_ILLEGAL: state_nxt = S_ILLEGAL;
      default:   state_nxt = S_FETCH;
    endcase
    // the board load request overrides everything, including a pending memory access
    if (load_edge) state_nxt = S_LOAD_PC;
  end

  assign retire = (state_nxt == S_FETCH) &&
                  (state inside {S_MEMWB, S_MEMWR, S_RTYPE_WB, S_BEQ, S_ADDI_WB, S_JUMP});

  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      state     <= S_FETCH;
      load_q    <= 1'b0;
      instr_cnt <= '0;
      illegal   <= 1'b0;
    end else begin
      state  <= state_nxt;
      load_q <= CTL_load;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      if (state_nxt == S_ILLEGAL) illegal <= 1'b1;
    end
  end

  assign CTL_state     = state;
  assign CTL_instr_cnt = instr_cnt;
  assign CTL_illegal   = illegal;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench: instruction-level model expands each instruction into its expected state
// sequence; one negedge process compares every cycle, plus literal spot checks.
module tb_mips_mc_controller;

  localparam int CNT_W = 4;

  logic             SYS_clk = 1'b0;
  logic             SYS_rst = 1'b1;
  logic             CTL_load = 1'b0;
  logic [5:0]       CTL_opcode = 6'd0;
  logic [5:0]       CTL_funct = 6'h20;
  logic             CTL_zero = 1'b0;
  logic             CTL_mem_ack = 1'b0;
  logic             CTL_mem_req, CTL_mem_we, CTL_iord, CTL_ir_write, CTL_pc_en;
  logic [1:0]       CTL_pc_src, CTL_alu_src_b, CTL_alu_op;
  logic             CTL_alu_src_a, CTL_reg_dst, CTL_mem_to_reg, CTL_reg_write;
  logic [3:0]       CTL_state;
  logic [CNT_W-1:0] CTL_instr_cnt;
  logic             CTL_illegal;

  mips_mc_controller #(.CNT_W(CNT_W)) dut (
    .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .CTL_load(CTL_load),
    .CTL_opcode(CTL_opcode), .CTL_funct(CTL_funct), .CTL_zero(CTL_zero),
    .CTL_mem_ack(CTL_mem_ack), .CTL_mem_req(CTL_mem_req), .CTL_mem_we(CTL_mem_we),
    .CTL_iord(CTL_iord), .CTL_ir_write(CTL_ir_write), .CTL_pc_en(CTL_pc_en),
    .CTL_pc_src(CTL_pc_src), .CTL_alu_src_a(CTL_alu_src_a), .CTL_alu_src_b(CTL_alu_src_b),
    .CTL_alu_op(CTL_alu_op), .CTL_reg_dst(CTL_reg_dst), .CTL_mem_to_reg(CTL_mem_to_reg),
    .CTL_reg_write(CTL_reg_write), .CTL_state(CTL_state), .CTL_instr_cnt(CTL_instr_cnt),
    .CTL_illegal(CTL_illegal)
  );

  always #5 SYS_clk = ~SYS_clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_no = 0;
  logic [23:0] expq[$];
  int lens[$];
  int run = 0;
  logic [3:0] prev_st = 4'd0;
  logic [5:0] cur_op = 6'd0;
  bit prev_ld = 1'b0;
  int exp_cnt = 0;
  bit exp_ill = 1'b0;

  wire [23:0] act = {CTL_state, CTL_mem_req, CTL_mem_we, CTL_iord, CTL_ir_write, CTL_pc_en,
                     CTL_pc_src, CTL_alu_src_a, CTL_alu_src_b, CTL_alu_op, CTL_reg_dst,
                     CTL_mem_to_reg, CTL_reg_write, CTL_illegal, CTL_instr_cnt};

  // Expected outputs for one cycle, straight from the per-state action table.
  function automatic logic [23:0] exp_vec(input int st, input bit ack, input bit zr, input bit le);
    logic req, we, iord, irw, pce, a, rd, m2r, rw;
    logic [1:0] src, b, op;
    {req, we, iord, irw, pce, a, rd, m2r, rw} = '0;
    {src, b, op} = '0;
    case (st)
      0:  begin req = 1; b = 1; irw = ack & ~le; pce = ack & ~le; end
      1:  b = 3;
      2:  begin a = 1; b = 2; end
      3:  begin req = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin req = 1; iord = 1; we = 1; end
      6:  begin a = 1; op = 2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin a = 1; op = 1; src = 1; pce = zr; end
      9:  begin a = 1; b = 2; end
      10: rw = 1;
      11: begin src = 2; pce = 1; end
      12: begin src = 3; pce = 1; end
      default: ;
    endcase
    return {4'(st), req, we, iord, irw, pce, src, a, b, op, rd, m2r, rw, exp_ill, 4'(exp_cnt)};
  endfunction

  // One clock cycle of stimulus plus the state the DUT must show during it.
  task automatic cyc(input int st, input bit ack, input bit zr, input bit ld, input bit rs);
    bit le;
    @(posedge SYS_clk); #1;
    CTL_mem_ack = ack; CTL_zero = zr; CTL_load = ld; SYS_rst = rs; CTL_opcode = cur_op;
    le = ld & ~prev_ld;
    prev_ld = ld;
    if (st == 15) exp_ill = 1'b1;
    expq.push_back(exp_vec(st, ack, zr, le));
    if (rs) begin exp_cnt = 0; exp_ill = 1'b0; prev_ld = 1'b0; end
  endtask

  // Expand a whole instruction into its expected state sequence.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit zr);
    cur_op = op;
    repeat (fw) cyc(0, 0, zr, 0, 0);
    cyc(0, 1, zr, 0, 0);
    cyc(1, 1, zr, 0, 0);
    case (op)
      LW:   begin cyc(2, 1, zr, 0, 0); repeat (mw) cyc(3, 0, zr, 0, 0);
                  cyc(3, 1, zr, 0, 0); cyc(4, 1, zr, 0, 0); end
      SW:   begin cyc(2, 1, zr, 0, 0); repeat (mw) cyc(5, 0, zr, 0, 0); cyc(5, 1, zr, 0, 0); end
      RT:   begin cyc(6, 1, zr, 0, 0); cyc(7, 1, zr, 0, 0); end
      ADDI: begin cyc(9, 1, zr, 0, 0); cyc(10, 1, zr, 0, 0); end
      BEQ:  cyc(8, 1, zr, 0, 0);
      JMP:  cyc(11, 1, zr, 0, 0);
      default: ;
    endcase
    exp_cnt = (exp_cnt + 1) % 16;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic chk_len(input int idx, input int want);
    n_chk++;
    if (idx >= lens.size()) begin
      n_fail++;
      $display("FAIL latency_%0d: no measurement, expected %0d", idx, want);
    end else if (lens[idx] != want) begin
      n_fail++;
      $display("FAIL latency_%0d: got %0d cycles expected %0d", idx, lens[idx], want);
    end
  endtask

  task automatic settle;
    @(negedge SYS_clk); #1;
  endtask

  // Per-cycle compare and instruction-length monitor.
  always @(negedge SYS_clk) begin
    cyc_no++;
    if (SYS_rst) run = 0;
    else if (CTL_state == 4'd0 && prev_st != 4'd0) begin lens.push_back(run); run = 1; end
    else run++;
    prev_st = CTL_state;
    if (expq.size() > 0) begin
      logic [23:0] v;
      v = expq.pop_front();
      n_chk++;
      if (act !== v) begin
        n_fail++;
        $display("FAIL cycle_%0d: got %h expected %h", cyc_no, act, v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge SYS_clk);
    settle();
    chk("rst_state", 32'(CTL_state), 0);
    chk("rst_cnt", 32'(CTL_instr_cnt), 0);
    chk("rst_illegal", 32'(CTL_illegal), 0);
    chk("rst_mem_req", 32'(CTL_mem_req), 1);
    chk("rst_iord", 32'(CTL_iord), 0);

    // instruction mix with ack tied high
    run_instr(LW, 0, 0, 0);
    run_instr(SW, 0, 0, 0);
    run_instr(RT, 0, 0, 0);
    run_instr(ADDI, 0, 0, 0);
    run_instr(BEQ, 0, 0, 1);
    run_instr(JMP, 0, 0, 0);

    // lw with 3 fetch waits and 2 read waits
    run_instr(LW, 3, 2, 0);
    chk_len(0, 5); chk_len(1, 4); chk_len(2, 4);
    chk_len(3, 4); chk_len(4, 3); chk_len(5, 3);
    settle();
    chk("cnt_after_mix", 32'(CTL_instr_cnt), 6);

    // reset for two cycles in the middle of MEMRD
    cur_op = LW;
    cyc(0, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(2, 1, 0, 0, 0); cyc(3, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    settle();
    chk_len(6, 10);
    chk("midrst_state", 32'(CTL_state), 0);
    chk("midrst_cnt", 32'(CTL_instr_cnt), 0);
    chk("midrst_illegal", 32'(CTL_illegal), 0);
    chk("midrst_mem_req", 32'(CTL_mem_req), 1);
    chk("midrst_iord", 32'(CTL_iord), 0);

    // branch not taken
    run_instr(BEQ, 0, 0, 0);

    // illegal opcode, frozen, then released by a load edge
    cur_op = 6'b111111;
    cyc(0, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    repeat (20) cyc(15, 1, 0, 0, 0);
    settle();
    chk("ill_state", 32'(CTL_state), 15);
    chk("ill_flag", 32'(CTL_illegal), 1);
    cyc(15, 1, 0, 1, 0);
    cyc(12, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    settle();
    chk("ill_sticky", 32'(CTL_illegal), 1);

    // load edge while MEMWR waits for ack
    cur_op = SW;
    cyc(0, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(2, 1, 0, 0, 0);
    cyc(5, 0, 0, 0, 0); cyc(5, 0, 0, 0, 0);
    cyc(5, 0, 0, 1, 0);
    cyc(12, 0, 0, 1, 0);
    settle();
    chk("ldw_state", 32'(CTL_state), 12);
    chk("ldw_mem_req", 32'(CTL_mem_req), 0);
    chk("ldw_cnt", 32'(CTL_instr_cnt), 1);
    cyc(0, 0, 0, 0, 0);

    // counter wrap at CNT_W=4
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) run_instr(RT, 0, 0, 0);
    settle();
    chk("wrap_pre", 32'(CTL_instr_cnt), 15);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("wrap_cnt", 32'(CTL_instr_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
